// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//
// Contents:
//   DATA_BITS      - payload bits per frame
//   IDLE_LEVEL     - level of the serial line when nothing is being sent
//   tx_state_t     - transmit FSM state encoding (StIdle .. StStop)
//   calc_bps_cnt() - clocks per bit for a given clock frequency and baud rate
//   parity_bit()   - parity bit for a data byte, even or odd
package uart_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam logic        IDLE_LEVEL = 1'b1;

  // Kept as plain constants so the encoding matches the existing receive path.
  typedef logic [2:0] tx_state_t;

  localparam tx_state_t StIdle   = 3'd0;
  localparam tx_state_t StStart  = 3'd1;
  localparam tx_state_t StData   = 3'd2;
  localparam tx_state_t StParity = 3'd3;
  localparam tx_state_t StStop   = 3'd4;

  // Integer-truncated clocks per bit.
  function automatic int unsigned calc_bps_cnt(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

  // odd = 0 gives even parity (total ones including the parity bit is even).
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Byte-stream handshake between a data source and the UART transmitter.
//
// Signals:
//   tx_data  - byte to send, meaningful only when tx_valid is high
//   tx_valid - source has a byte
//   tx_ready - transmitter can accept a byte this cycle
// Modports:
//   master - the byte source
//   slave  - the transmitter
interface uart_tx_ctrl_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer for the UART transmitter.
//
// Ports:
//   clk     - system clock
//   rst     - asynchronous active-high reset
//   enable  - count while a frame is in progress; held at zero otherwise
//   restart - force the count back to zero (start of a new frame)
//   bit_end - one-cycle pulse on the last clock of every bit period
// Parameters:
//   BPS_CNT - clocks per bit
module uart_baud_gen #(
  parameter int unsigned BPS_CNT = 217
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic restart,
  output logic bit_end
);

  localparam int unsigned    CntW    = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(BPS_CNT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign bit_end = enable && (cnt_q == LastCnt);

  // The count wraps on bit_end so the next bit starts from zero without a gap.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!enable || restart || bit_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: serialises bytes from a valid/ready source as
// start bit, 8 data bits (LSB first), optional parity bit, 1 or 2 stop bits.
// A one-entry holding register lets the next byte queue up during a frame so
// consecutive frames leave no idle gap on the line.
//
// Ports:
//   clk     - system clock
//   rst     - asynchronous active-high reset; aborts any frame in progress
//   tx_if   - slave side of the byte handshake (tx_data/tx_valid/tx_ready)
//   uart_tx - serial line, idle high, registered
//   tx_busy - high while a frame is on the line
//   tx_done - one-cycle pulse in the first cycle after the final stop bit
// Parameters:
//   CLK_FREQ, BAUD - set the bit period (CLK_FREQ / BAUD clocks)
//   PARITY_EN      - 1 inserts a parity bit after data bit 7
//   PARITY_ODD     - 0 even parity, 1 odd parity
//   STOP_BITS      - 1 or 2
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 25000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_ctrl_if.slave  tx_if,
  output logic           uart_tx,
  output logic           tx_busy,
  output logic           tx_done
);

  localparam int unsigned BPS_CNT     = calc_bps_cnt(CLK_FREQ, BAUD);
  localparam logic        ParOdd      = (PARITY_ODD != 0);
  localparam logic [2:0]  LastDataIdx = 3'(DATA_BITS - 1);
  localparam logic        LastStopIdx = (STOP_BITS >= 2);

  tx_state_t            state_q, state_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic                 line_q, line_d;
  logic                 busy_q;
  logic                 done_pre_q, done_q;

  logic load;
  logic frame_end;
  logic accept;
  logic bit_end;

  // tx_ready is low whenever the holding register is full, so an accept can
  // never coincide with the FSM unloading it.
  assign tx_if.tx_ready = !hold_full_q;
  assign accept         = tx_if.tx_valid && !hold_full_q;

  uart_baud_gen #(
    .BPS_CNT (BPS_CNT)
  ) u_baud_gen (
    .clk     (clk),
    .rst     (rst),
    .enable  (state_q != StIdle),
    .restart (load),
    .bit_end (bit_end)
  );

  // Frame sequencing.
  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    load       = 1'b0;
    frame_end  = 1'b0;

    case (state_q)
      StIdle: begin
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          bit_idx_d = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == LastDataIdx) begin
            state_d    = (PARITY_EN != 0) ? StParity : StStop;
            stop_idx_d = 1'b0;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d    = StStop;
          stop_idx_d = 1'b0;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (stop_idx_q == LastStopIdx) begin
            frame_end = 1'b1;
            // Chain straight into the next frame when a byte is waiting.
            if (hold_full_q) begin
              load    = 1'b1;
              state_d = StStart;
            end else begin
              state_d = StIdle;
            end
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Parity is fixed at load time since the shift register is consumed.
    if (load) begin
      shift_d = hold_q;
      par_d   = parity_bit(hold_q, ParOdd);
    end
  end

  // Holding register.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (load) begin
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_d      = tx_if.tx_data;
      hold_full_d = 1'b1;
    end
  end

  // Line level for the current state; registered so uart_tx is glitch-free.
  always_comb begin
    case (state_q)
      StStart:  line_d = 1'b0;
      StData:   line_d = shift_q[0];
      StParity: line_d = par_q;
      default:  line_d = IDLE_LEVEL;
    endcase
  end

  // busy/done are delayed one cycle like the line so all three stay aligned;
  // done needs a second stage to land after the final stop bit leaves the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      line_q      <= IDLE_LEVEL;
      busy_q      <= 1'b0;
      done_pre_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      stop_idx_q  <= stop_idx_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      line_q      <= line_d;
      busy_q      <= (state_q != StIdle);
      done_pre_q  <= frame_end;
      done_q      <= done_pre_q;
    end
  end

  assign uart_tx = line_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl. Four instances at the default bit period:
//   0: 8N1   1: 8E1   2: 8O1   3: 8N2
// Expected waveforms are built per clock from the frame definition.
module tb_uart_tx_ctrl;

  localparam int B  = 217;
  localparam int TO = 6000;

  int pe_cfg[4] = '{0, 1, 1, 0};
  int od_cfg[4] = '{0, 0, 1, 0};
  int st_cfg[4] = '{1, 1, 1, 2};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [7:0] d [4];
  logic [3:0] v = '0;
  logic [3:0] line_w, busy_w, done_w, rdy_w;

  uart_tx_ctrl_if u_if0 ();
  uart_tx_ctrl_if u_if1 ();
  uart_tx_ctrl_if u_if2 ();
  uart_tx_ctrl_if u_if3 ();

  assign u_if0.tx_data = d[0];
  assign u_if1.tx_data = d[1];
  assign u_if2.tx_data = d[2];
  assign u_if3.tx_data = d[3];
  assign u_if0.tx_valid = v[0];
  assign u_if1.tx_valid = v[1];
  assign u_if2.tx_valid = v[2];
  assign u_if3.tx_valid = v[3];
  assign rdy_w = {u_if3.tx_ready, u_if2.tx_ready, u_if1.tx_ready, u_if0.tx_ready};

  uart_tx_ctrl u_dut0 (
    .clk(clk), .rst(rst), .tx_if(u_if0),
    .uart_tx(line_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0])
  );
  uart_tx_ctrl #(.PARITY_EN(1)) u_dut1 (
    .clk(clk), .rst(rst), .tx_if(u_if1),
    .uart_tx(line_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1])
  );
  uart_tx_ctrl #(.PARITY_EN(1), .PARITY_ODD(1)) u_dut2 (
    .clk(clk), .rst(rst), .tx_if(u_if2),
    .uart_tx(line_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2])
  );
  uart_tx_ctrl #(.STOP_BITS(2)) u_dut3 (
    .clk(clk), .rst(rst), .tx_if(u_if3),
    .uart_tx(line_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3])
  );

  bit exp_line[$], exp_busy[$], exp_done[$];
  bit obs_line[$], obs_busy[$], obs_done[$];

  function automatic int frame_len(input int k);
    return (1 + 8 + pe_cfg[k] + st_cfg[k]) * B;
  endfunction

  // Reference: per-clock line/busy/done from the first start-bit cycle onward.
  task automatic build_exp(input int k, input logic [7:0] bytes[$], input int tail);
    exp_line.delete();
    exp_busy.delete();
    exp_done.delete();
    foreach (bytes[i]) begin
      bit lvl[$];
      lvl.delete();
      lvl.push_back(1'b0);
      for (int j = 0; j < 8; j++) lvl.push_back(bytes[i][j]);
      if (pe_cfg[k] != 0) lvl.push_back(bit'(($countones(bytes[i]) + od_cfg[k]) % 2));
      for (int s = 0; s < st_cfg[k]; s++) lvl.push_back(1'b1);
      foreach (lvl[j]) begin
        for (int c = 0; c < B; c++) begin
          exp_line.push_back(lvl[j]);
          exp_busy.push_back(1'b1);
          exp_done.push_back(1'b0);
        end
      end
    end
    for (int c = 0; c < tail; c++) begin
      exp_line.push_back(1'b1);
      exp_busy.push_back(1'b0);
      exp_done.push_back(1'b0);
    end
    for (int i = 1; i <= bytes.size(); i++) exp_done[i * frame_len(k)] = 1'b1;
  endtask

  function automatic int count_diff(input bit a[$], input bit b[$]);
    int n = 0;
    if (a.size() != b.size()) return 1 + a.size() + b.size();
    foreach (a[i]) if (a[i] !== b[i]) n++;
    return n;
  endfunction

  function automatic int count_ones(input bit a[$]);
    int n = 0;
    foreach (a[i]) if (a[i]) n++;
    return n;
  endfunction

  function automatic int first_one(input bit a[$]);
    foreach (a[i]) if (a[i]) return i;
    return -1;
  endfunction

  // Presents bytes with tx_valid held high; acc_cyc is the first accepting edge.
  task automatic send_seq(input int k, input logic [7:0] bytes[$], output int acc_cyc);
    acc_cyc = -1;
    v[k] = 1'b1;
    foreach (bytes[i]) begin
      int n;
      n = 0;
      d[k] = bytes[i];
      while (rdy_w[k] !== 1'b1 && n < TO) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= TO) begin
        checks++; errors++;
        $display("FAIL send_timeout dut%0d: tx_ready=%b, required 1", k, rdy_w[k]);
        break;
      end
      @(posedge clk); #1;
      if (i == 0) acc_cyc = cyc;
    end
    v[k] = 1'b0;
  endtask

  // Waits for the start bit, then records ncyc cycles beginning with it.
  task automatic capture(input int k, input int ncyc, output int start_cyc);
    int n;
    n = 0;
    start_cyc = -1;
    obs_line.delete();
    obs_busy.delete();
    obs_done.delete();
    while (line_w[k] !== 1'b0 && n < TO) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= TO) begin
      checks++; errors++;
      $display("FAIL start_timeout dut%0d: uart_tx=%b, required 0", k, line_w[k]);
    end else begin
      start_cyc = cyc;
      for (int c = 0; c < ncyc; c++) begin
        obs_line.push_back(line_w[k]);
        obs_busy.push_back(busy_w[k]);
        obs_done.push_back(done_w[k]);
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    v = '0;
    for (int k = 0; k < 4; k++) d[k] = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (line_w !== 4'hF) begin errors++; $display("FAIL reset_line: got %b, required 1111", line_w); end
    checks++;
    if (rdy_w !== 4'hF) begin errors++; $display("FAIL reset_ready: got %b, required 1111", rdy_w); end
    checks++;
    if (busy_w !== 4'h0) begin errors++; $display("FAIL reset_busy: got %b, required 0000", busy_w); end
    checks++;
    if (done_w !== 4'h0) begin errors++; $display("FAIL reset_done: got %b, required 0000", done_w); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [7:0] q[$];
    int acc, st, nd;
    q = '{8'h55};
    build_exp(0, q, 4);
    fork
      send_seq(0, q, acc);
      capture(0, exp_line.size(), st);
    join
    checks++;
    if ((st - acc) !== 2) begin errors++; $display("FAIL basic_latency: got %0d, required 2", st - acc); end
    nd = count_diff(obs_line, exp_line);
    checks++;
    if (nd !== 0) begin errors++; $display("FAIL basic_line: %0d bad cycles, required 0", nd); end
    nd = count_diff(obs_busy, exp_busy);
    checks++;
    if (nd !== 0) begin errors++; $display("FAIL basic_busy: %0d bad cycles, required 0", nd); end
    checks++;
    if (first_one(obs_done) !== 10 * B || count_ones(obs_done) !== 1) begin
      errors++;
      $display("FAIL basic_done: first at %0d (%0d pulses), required %0d (1 pulse)",
               first_one(obs_done), count_ones(obs_done), 10 * B);
    end
  endtask

  task automatic test_parity();
    logic [7:0] q[$];
    int acc, st, nd;
    bit par_exp;
    q = '{8'h07};
    for (int k = 1; k <= 2; k++) begin
      par_exp = (k == 1) ? 1'b1 : 1'b0;
      build_exp(k, q, 4);
      fork
        send_seq(k, q, acc);
        capture(k, exp_line.size(), st);
      join
      checks++;
      if (obs_line.size() <= 9 * B + B / 2 || obs_line[9 * B + B / 2] !== par_exp) begin
        errors++;
        $display("FAIL parity_bit dut%0d: got %b, required %b", k,
                 (obs_line.size() > 9 * B + B / 2) ? obs_line[9 * B + B / 2] : 1'bx, par_exp);
      end
      nd = count_diff(obs_line, exp_line);
      checks++;
      if (nd !== 0) begin errors++; $display("FAIL parity_line dut%0d: %0d bad cycles", k, nd); end
      checks++;
      if (count_ones(obs_busy) !== 2387) begin
        errors++;
        $display("FAIL parity_len dut%0d: got %0d, required 2387", k, count_ones(obs_busy));
      end
    end
  endtask

  task automatic test_stop2();
    logic [7:0] q[$];
    int acc, st, nd;
    q = '{8'hFF};
    build_exp(3, q, 4);
    fork
      send_seq(3, q, acc);
      capture(3, exp_line.size(), st);
    join
    nd = count_diff(obs_line, exp_line);
    checks++;
    if (nd !== 0) begin errors++; $display("FAIL stop2_line: %0d bad cycles, required 0", nd); end
    nd = count_diff(obs_busy, exp_busy);
    checks++;
    if (nd !== 0) begin errors++; $display("FAIL stop2_busy: %0d bad cycles, required 0", nd); end
    checks++;
    if (first_one(obs_done) !== 11 * B) begin
      errors++;
      $display("FAIL stop2_done: got %0d, required %0d", first_one(obs_done), 11 * B);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    int acc, st, nd;
    q = '{8'hA3, 8'h3C};
    build_exp(0, q, 4);
    fork
      send_seq(0, q, acc);
      capture(0, exp_line.size(), st);
    join
    nd = count_diff(obs_line, exp_line);
    checks++;
    if (nd !== 0) begin errors++; $display("FAIL b2b_line: %0d bad cycles, required 0", nd); end
    nd = count_diff(obs_busy, exp_busy);
    checks++;
    if (nd !== 0) begin errors++; $display("FAIL b2b_busy: %0d bad cycles, required 0", nd); end
    nd = count_diff(obs_done, exp_done);
    checks++;
    if (nd !== 0 || count_ones(obs_done) !== 2) begin
      errors++;
      $display("FAIL b2b_done: %0d bad cycles, %0d pulses, required 0 and 2", nd,
               count_ones(obs_done));
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] q[$];
    int acc, st, nd, done_seen, line_bad;
    q = '{8'h0F};
    fork
      send_seq(0, q, acc);
      capture(0, 5 * B + B / 2, st);
    join
    checks++;
    if (line_w[0] !== q[0][4]) begin
      errors++; $display("FAIL mid_bit4: got %b, required %b", line_w[0], q[0][4]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (line_w[0] !== 1'b1 || rdy_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_abort: line=%b ready=%b busy=%b, required 1 1 0",
               line_w[0], rdy_w[0], busy_w[0]);
    end
    done_seen = 0;
    line_bad = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done_w[0]) done_seen++;
    end
    rst = 1'b0;
    repeat (5 * B) begin
      @(posedge clk); #1;
      if (done_w[0]) done_seen++;
      if (line_w[0] !== 1'b1) line_bad++;
    end
    checks++;
    if (done_seen !== 0) begin errors++; $display("FAIL mid_no_done: got %0d pulses, required 0", done_seen); end
    checks++;
    if (line_bad !== 0) begin errors++; $display("FAIL mid_idle_line: %0d low cycles, required 0", line_bad); end
    q = '{8'h81};
    build_exp(0, q, 4);
    fork
      send_seq(0, q, acc);
      capture(0, exp_line.size(), st);
    join
    nd = count_diff(obs_line, exp_line) + count_diff(obs_busy, exp_busy) +
         count_diff(obs_done, exp_done);
    checks++;
    if (nd !== 0) begin errors++; $display("FAIL mid_clean_frame: %0d bad samples, required 0", nd); end
  endtask

  task automatic test_ignore();
    logic [7:0] q[$];
    int acc, st, nd;
    logic rdy_at_pulse;
    q = '{8'h12, 8'h34};
    build_exp(0, q, 4);
    fork
      send_seq(0, q, acc);
      capture(0, exp_line.size(), st);
      begin
        repeat (3 * B) @(posedge clk);
        #1;
        rdy_at_pulse = rdy_w[0];
        d[0] = 8'hEE;
        v[0] = 1'b1;
        @(posedge clk); #1;
        v[0] = 1'b0;
      end
    join
    checks++;
    if (rdy_at_pulse !== 1'b0) begin errors++; $display("FAIL ign_ready: got %b, required 0", rdy_at_pulse); end
    nd = count_diff(obs_line, exp_line) + count_diff(obs_done, exp_done);
    checks++;
    if (nd !== 0) begin errors++; $display("FAIL ign_line: %0d bad samples, required 0", nd); end
    checks++;
    if (rdy_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
      errors++; $display("FAIL ign_after: ready=%b busy=%b, required 1 0", rdy_w[0], busy_w[0]);
    end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    int acc, st, nd, k, n;
    for (int it = 0; it < 4; it++) begin
      k = $urandom_range(3, 0);
      n = $urandom_range(2, 1);
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      build_exp(k, q, 3);
      fork
        send_seq(k, q, acc);
        capture(k, exp_line.size(), st);
      join
      nd = count_diff(obs_line, exp_line);
      checks++;
      if (nd !== 0) begin errors++; $display("FAIL rand_line it%0d dut%0d: %0d bad cycles", it, k, nd); end
      nd = count_diff(obs_busy, exp_busy);
      checks++;
      if (nd !== 0) begin errors++; $display("FAIL rand_busy it%0d dut%0d: %0d bad cycles", it, k, nd); end
      nd = count_diff(obs_done, exp_done);
      checks++;
      if (nd !== 0) begin errors++; $display("FAIL rand_done it%0d dut%0d: %0d bad cycles", it, k, nd); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_stop2();
    test_back_to_back();
    test_reset_mid();
    test_ignore();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
UART transmitter for the chassis FPGA link. It serialises bytes from a valid/ready source onto the RS232 TX line as 1 start bit, 8 data bits (LSB first), an optional parity bit and 1 or 2 stop bits. An internal baud counter times each bit, and a one-entry holding buffer allows back-to-back frames with no idle gap. It is the transmit-side counterpart of the existing UART receive path.

Parameters:
CLK_FREQ, 25000000, system clock frequency in Hz
BAUD, 115200, line bit rate
PARITY_EN, 0, 1 inserts a parity bit after data bit 7
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)
STOP_BITS, 1, number of stop bits; legal values are 1 and 2

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
tx_data  input  8  byte to send, sampled when tx_valid & tx_ready
tx_valid  input  1  source has a byte
tx_ready  output  1  holding buffer empty, can accept a byte
uart_tx  output  1  serial line, idle high, registered
tx_busy  output  1  a frame is on the line (start bit through last stop bit)
tx_done  output  1  single-cycle pulse after the last stop bit completes

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-high on rst. While rst=1: uart_tx=1, tx_ready=1, tx_busy=0, tx_done=0, holding buffer empty, FSM in IDLE, baud counter 0. Asserting rst mid-frame aborts the frame and drives the line high immediately.
- Bit period: BPS_CNT = CLK_FREQ/BAUD, integer-truncated; 217 at the defaults. Every bit, including each stop bit, holds for exactly BPS_CNT clocks. The baud counter runs only while tx_busy=1 and restarts at 0 at the start of each bit.
- Handshake: a transfer occurs on any rising edge where tx_valid=1 and tx_ready=1. At that edge tx_data is written to the holding register and tx_ready drops on the next cycle. tx_ready rises again in the cycle after the FSM moves the byte into the shift register. tx_data is don't-care when no transfer occurs.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if the holding buffer is full, load the shift register, clear the buffer and go to START. uart_tx=0 starting the next cycle. Latency from the accepting edge to the start-bit edge is 2 clocks.
  - START: drive 0 for BPS_CNT clocks, then go to DATA with bit index 0.
  - DATA: drive shift[0] and shift right at the end of each bit. After bit index 7, go to PARITY if PARITY_EN=1, otherwise go to STOP.
  - PARITY: drive (^byte) ^ PARITY_ODD for one bit period, then go to STOP.
  - STOP: drive 1 for STOP_BITS × BPS_CNT clocks. At the end of the final stop bit:
    - if the buffer is full, load it and go directly to START (zero idle cycles between frames);
    - otherwise go to IDLE.
- tx_done: high for exactly one cycle, the first cycle after the final stop bit. This holds in both the back-to-back and the idle case.
- tx_busy: 1 in START, DATA, PARITY and STOP; 0 in IDLE.
- Simultaneous events: a handshake on the same edge the FSM unloads the buffer is impossible, because tx_ready=0 whenever the buffer is full. A handshake on the cycle the buffer empties is accepted normally.
- Frame length: (1 + 8 + PARITY_EN + STOP_BITS) × BPS_CNT clocks.

Decomposition:
- Package uart_pkg:
  - tx FSM state enum
  - function calc_bps_cnt(CLK_FREQ, BAUD)
  - function parity_bit(byte, odd)
  - constants DATA_BITS=8, IDLE_LEVEL=1'b1
- Sub-module uart_baud_gen:
  - inputs: clk, rst, enable, restart
  - output: bit_end, a one-cycle pulse on the last clock of each bit period
  - parameter: BPS_CNT
- The transmitter instantiates uart_baud_gen once and contains the FSM, shift register and holding buffer.

Test Plan:
1. Defaults (BPS_CNT=217), send 0x55 → line reads 0,1,0,1,0,1,0,1,0,1. Each level lasts 217 clocks, the frame lasts 2170 clocks, and tx_done pulses once, 2170 clocks after the start-bit edge.
2. PARITY_EN=1, send 0x07 → parity bit 1 with even parity; PARITY_ODD=1 gives parity bit 0. The frame lasts 2387 clocks.
3. tx_valid held high with 0xA3 then 0x3C → the second byte is accepted during the first frame. The second start bit begins on the clock immediately after the first frame's final stop bit, with no idle gap, and tx_done pulses twice.
4. STOP_BITS=2, send 0xFF → the stop level lasts 434 clocks, and tx_busy falls only after both stop bits.
5. Assert rst for 3 clocks in the middle of data bit 4 → uart_tx=1 immediately, tx_ready=1, tx_busy=0 and no tx_done pulse. The next byte sent (0x81) produces a clean frame.
6. tx_valid pulsed while tx_ready=0 → the byte is ignored and the line output is unchanged.
